// File: rtl/kuznechik_inv_l.sv
// Kuznechik inverse linear transform L^-1: sixteen inverse R steps applied to one 128-bit block.
// Latency: put sampled at edge N -> ready pulse and valid res in the cycle after edge N+16, both builds.
// Backpressure: iterative build drops accept while a block is in flight and ignores put then; pipelined build always accepts.
//
// Build option: define KUZ_INV_L_PIPE_EN for the fully unrolled pipeline (one block per cycle).
// Without it, a single inverse R unit is reused under an IDLE/RUN FSM (one block per 17 cycles).
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset; clears res, ready and all in-flight state
//   put    - input strobe, sampled while accept = 1
//   data   - input block, byte j = data[8j+7:8j]
//   accept - a new block can be taken this cycle
//   res    - L^-1(data), valid while ready = 1
//   ready  - one-cycle pulse per completed block
module kuznechik_inv_l #(
    parameter int ROUNDS = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         put,
    input  logic [127:0] data,
    output logic         accept,
    output logic [127:0] res,
    output logic         ready
);

    // Coefficient vector packed so that byte i holds c[i]:
    // c = 01,94,20,85,10,C2,C0,01,FB,01,C0,C2,10,85,20,94
    localparam logic [127:0] COEF = 128'h94_20_85_10_C2_C0_01_FB_01_C0_C2_10_85_20_94_01;

    // GF(2^8) multiply modulo x^8+x^7+x^6+x+1. One operand is always a constant,
    // so synthesis folds each call into a small XOR network.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'hC3) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // One inverse R step: byte 0 plus the weighted sum of bytes 1..15 becomes the
    // new top byte while the rest of the block shifts down by one byte.
    function automatic logic [127:0] inv_r(input logic [127:0] t);
        logic [7:0] acc;
        acc = t[7:0];
        for (int j = 1; j < 16; j++) begin
            acc = acc ^ gf_mul(t[8*j +: 8], COEF[8*(16-j) +: 8]);
        end
        return {acc, t[127:8]};
    endfunction

`ifdef KUZ_INV_L_PIPE_EN

    // stage_q[0] only registers the input; stage_q[i] holds i rounds and the
    // output register applies the last round, giving ROUNDS compute stages.
    logic [127:0]      stage_q [ROUNDS];
    logic [ROUNDS-1:0] vld_q;

    assign accept = 1'b1;

    // Datapath carries no reset: its contents are qualified by vld_q.
    always_ff @(posedge clk) begin
        stage_q[0] <= data;
        for (int i = 1; i < ROUNDS; i++) begin
            stage_q[i] <= inv_r(stage_q[i-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            res   <= '0;
            ready <= 1'b0;
        end else begin
            vld_q <= {vld_q[ROUNDS-2:0], put};
            res   <= inv_r(stage_q[ROUNDS-1]);
            ready <= vld_q[ROUNDS-1];
        end
    end

`else

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [4:0] LAST = 5'(ROUNDS - 1);

    state_t       state_q;
    state_t       state_d;
    logic [127:0] work_q;
    logic [127:0] work_d;
    logic [127:0] res_d;
    logic [127:0] round_out;
    logic [4:0]   cnt_q;
    logic [4:0]   cnt_d;
    logic         ready_d;

    assign round_out = inv_r(work_q);

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        res_d   = res;
        ready_d = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                accept = 1'b1;
                if (put) begin
                    work_d  = data;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d = round_out;
                cnt_d  = cnt_q + 5'd1;
                // cnt_q counts rounds already applied; this edge applies the last one.
                if (cnt_q == LAST) begin
                    res_d   = round_out;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            res     <= '0;
            ready   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            res     <= res_d;
            ready   <= ready_d;
        end
    end

`endif

endmodule

// File: doc/kuznechik_inv_l.md
# kuznechik_inv_l

Inverse linear transform L⁻¹ of the Kuznechik (GOST R 34.12-2015) cipher. It consumes a 128-bit block with a `put` strobe and returns L⁻¹(block) with a `ready` strobe. It sits in the decryption datapath between the round-key XOR and the inverse S-box layer, mirroring the forward `funcL` pipeline. It is built either as a 16-stage pipeline or as a single iterative R⁻¹ unit (see Configuration).

## Interface
Parameters:
- `ROUNDS`, default 16: number of R⁻¹ applications; fixed at 16 for GOST, exposed only for bench bring-up.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `put`  in  1: input valid. Sampled on a rising edge while `accept`=1.
- `data`  in  128: input block. Byte j is `data[8j+7:8j]`.
- `accept`  out  1: block can take a new input this cycle.
- `res`  out  128: L⁻¹(data). Valid while `ready`=1.
- `ready`  out  1: one-cycle pulse per completed block.

## Operation
- GF(2⁸) multiply uses polynomial x⁸+x⁷+x⁶+x+1 (reduction constant 0xC3), the same as `multGF`.
- The coefficient vector c[0..15] is 01,94,20,85,10,C2,C0,01,FB,01,C0,C2,10,85,20,94 (hex), the same as the forward `l_vec`.
- One R⁻¹ step on t (t_j = byte j):
  - lin(t) = t_0 XOR (XOR over j=1..15 of gf_mul(t_j, c[16−j])).
  - R⁻¹(t) = {lin(t), t[127:8]}, i.e. shift down one byte and insert lin into bits [127:120].
  - This exactly undoes one forward `funcR` step in default (little-endian byte) ordering.
- L⁻¹ = 16 applications of R⁻¹.
- `put` while `accept`=0 is silently dropped. No error flag.

Iterative mode FSM:
- IDLE: `accept`=1. When `put` is sampled: work ← `data`, cnt ← 0, go to RUN.
- RUN: `accept`=0. Each cycle: work ← R⁻¹(work), cnt ← cnt+1.
  - On the edge that applies round 16: `res` ← result, `ready` ← 1, go to IDLE.
- `res` is a separate register from work. It holds the last result until the next completion.

Pipelined mode:
- `accept` is constant 1.
- 16 register stages, each computing one R⁻¹.
- A 16-bit valid shift register carries `put` alongside the data and drives `ready`.

Reset, asserted at any time including mid-operation:
- `res`=0, `ready`=0, FSM → IDLE, cnt=0, pipeline valid bits=0.
- Any in-flight block is lost and produces no `ready`.
- `accept` reads 1 as soon as reset is released. During reset it is 1 in iterative mode (combinational from IDLE) and 1 in pipelined mode.

## Timing
- Latency, both modes: `put` sampled at edge N → `ready`=1 and `res` valid during the cycle after edge N+16.
- Throughput:
  - Pipelined: one block per cycle. Back-to-back `put` gives back-to-back `ready`.
  - Iterative: one block per 17 cycles. `accept` returns to 1 in the same cycle `ready` is high, so a `put` in that cycle is sampled at edge N+17.
- `ready` is never high for more than one cycle per accepted block.
- Pipelined `res` changes every cycle and is valid only with `ready`. Iterative `res` is stable between completions.

## Configuration
- Macro `KUZ_INV_L_PIPE_EN`.
- Defined: fully unrolled 16-stage pipeline, `accept` tied to 1, about 16× the R⁻¹ logic.
- Undefined (default): iterative single R⁻¹ unit with the IDLE/RUN FSM and a 5-bit round counter.
- Port list, latency and results are identical in both modes. Only throughput and `accept` behaviour differ.

## Test plan
- GOST vector:
  - Stimulus: `put` with `data`=128'h0d89a27f4b6e16c34ce8e3d04d5856d4 (GOST A.1.3 output, byte-reversed).
  - Response: 16 cycles later `ready`=1 and `res`=128'h94a564.
- Round-trip:
  - Stimulus: `data`=128'h00112233445566778899aabbccddeeff through `funcL`, then into this block.
  - Response: `res`=128'h00112233445566778899aabbccddeeff. Repeat with 1000 random blocks; all must match.
- Zero input:
  - Stimulus: `data`=0.
  - Response: `res`=0 and exactly one `ready` pulse at latency 16.
- Backpressure (iterative):
  - Stimulus: `put` held high for 40 cycles with a distinct block each cycle.
  - Response: only the blocks at cycles 0, 17 and 34 are accepted. `ready` pulses at 16 and 33 with the matching results. `accept`=0 during cycles 1–16.
- Streaming (pipelined):
  - Stimulus: 20 consecutive `put`s.
  - Response: 20 consecutive `ready` cycles starting at latency 16, in order, each with the correct result.
- Reset mid-run:
  - Stimulus: assert `rst_n`=0 at 8 cycles after `put`, release 2 cycles later.
  - Response: `res`=0 and `ready`=0 immediately. No `ready` for the lost block. `accept`=1 after release. The next block completes normally.
